// File: rtl/regfile_arb_pkg.sv
// Shared types and sizes for the regfile write arbiter.
// State enum, write bundle, address/data widths.
package regfile_arb_pkg;

  localparam int ADDR_W   = 2;
  localparam int DATA_W   = 4;
  localparam int NENTRIES = 4;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant, purely combinational.
// req[1:0] in, prio picks req[1] on conflict, en gates; gnt one-hot or 0.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] gnt
);

  assign gnt[0] = en & req[0] & (~req[1] | ~prio);
  assign gnt[1] = en & req[1] & (~req[0] |  prio);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between A and B; clears all entries
// after reset or on a clear pulse. Ports: a_*/b_* handshakes, clear, busy, rf_*.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter logic [DATA_W-1:0] CLEAR_VAL = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_val,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_rdy,
  input  logic              b_val,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_rdy,
  input  logic              clear,
  output logic              busy,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  state_t            st;
  logic [ADDR_W-1:0] cnt;
  logic              prio;
  rf_wr_t            wr;
  logic [1:0]        gnt;
  logic              hs_a;
  logic              hs_b;

  rr_arb2 u_arb (
    .req  ({b_val, a_val}),
    .prio (prio),
    .en   (st == RUN),
    .gnt  (gnt)
  );

  // gnt already includes the valid, so a grant is a handshake
  assign hs_a  = gnt[0];
  assign hs_b  = gnt[1];
  assign a_rdy = gnt[0];
  assign b_rdy = gnt[1];
  assign busy  = (st == CLEAR);

  assign rf_wen   = wr.wen;
  assign rf_waddr = wr.addr;
  assign rf_wdata = wr.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st   <= CLEAR;
      cnt  <= '0;
      prio <= 1'b0;
      wr   <= '0;
    end else begin
      unique case (st)
        CLEAR: begin
          wr <= '{wen: 1'b1, addr: cnt, data: CLEAR_VAL};
          if (cnt == ADDR_W'(NENTRIES - 1)) begin
            st <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          unique case (1'b1)
            hs_a: begin
              wr   <= '{wen: 1'b1, addr: a_addr, data: a_data};
              prio <= 1'b1;
            end
            hs_b: begin
              wr   <= '{wen: 1'b1, addr: b_addr, data: b_data};
              prio <= 1'b0;
            end
            default: wr.wen <= 1'b0;
          endcase
          // a handshake in the same cycle still lands before the clear
          if (clear) begin
            st  <= CLEAR;
            cnt <= '0;
          end
        end
        default: st <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a write scoreboard
// and a behavioural 4x4 regfile fed by rf_*.
module tb_regfile_write_arbiter;

  typedef struct {
    logic [1:0] a;
    logic [3:0] d;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       a_val;
  logic [1:0] a_addr;
  logic [3:0] a_data;
  logic       a_rdy;
  logic       b_val;
  logic [1:0] b_addr;
  logic [3:0] b_data;
  logic       b_rdy;
  logic       clear;
  logic       busy;
  logic       rf_wen;
  logic [1:0] rf_waddr;
  logic [3:0] rf_wdata;

  logic [3:0] rfm [4];
  exp_t       sb [$];
  int         total;
  int         bad;

  regfile_write_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_val    (a_val),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_rdy    (a_rdy),
    .b_val    (b_val),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_rdy    (b_rdy),
    .clear    (clear),
    .busy     (busy),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_wen) rfm[rf_waddr] <= rf_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] a, input logic [3:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic push_clear;
    for (int i = 0; i < 4; i++) push(2'(i), 4'h0);
  endtask

  // write monitor: every rf_wen cycle must match the next expected write
  always begin
    exp_t e;
    @(negedge clk);
    #3;
    chk("both_rdy", 32'(a_rdy & b_rdy), 32'd0);
    if (rf_wen) begin
      if (sb.size() == 0) begin
        chk("unexpected_wr", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(rf_waddr), 32'(e.a));
        chk("wr_data", 32'(rf_wdata), 32'(e.d));
      end
    end
  end

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b1;
    a_val  = 1'b0;
    a_addr = '0;
    a_data = '0;
    b_val  = 1'b0;
    b_addr = '0;
    b_data = '0;
    clear  = 1'b0;
    for (int i = 0; i < 4; i++) rfm[i] = 4'h7;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wen", 32'(rf_wen), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_ardy", 32'(a_rdy), 32'd0);
    chk("rst_brdy", 32'(b_rdy), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // reset release: four clear writes, busy falls with the last
    push_clear();
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      chk("clr_busy", 32'(busy), (i < 3) ? 32'd1 : 32'd0);
      chk("clr_wen", 32'(rf_wen), 32'd1);
    end
    step();
    #1;
    chk("clr_done_wen", 32'(rf_wen), 32'd0);
    for (int i = 0; i < 4; i++) chk("clr_rf", 32'(rfm[i]), 32'd0);

    // both valid: A first (prio 0), then B, then A again
    a_val  = 1'b1;
    a_addr = 2'd1;
    a_data = 4'hA;
    b_val  = 1'b1;
    b_addr = 2'd2;
    b_data = 4'hB;
    #1;
    chk("rr1_ardy", 32'(a_rdy), 32'd1);
    chk("rr1_brdy", 32'(b_rdy), 32'd0);
    push(2'd1, 4'hA);
    step();
    a_addr = 2'd0;
    a_data = 4'h6;
    #1;
    chk("rr2_brdy", 32'(b_rdy), 32'd1);
    chk("rr2_ardy", 32'(a_rdy), 32'd0);
    push(2'd2, 4'hB);
    step();
    b_val = 1'b0;
    #1;
    chk("rr3_ardy", 32'(a_rdy), 32'd1);
    push(2'd0, 4'h6);
    step();
    a_val = 1'b0;
    step();
    step();
    #1;
    chk("rr_rf1", 32'(rfm[1]), 32'hA);
    chk("rr_rf2", 32'(rfm[2]), 32'hB);
    chk("rr_rf0", 32'(rfm[0]), 32'h6);

    // B alone, back to back
    for (int i = 0; i < 4; i++) begin
      b_val  = 1'b1;
      b_addr = 2'(i);
      b_data = 4'(i + 1);
      #1;
      chk("b2b_brdy", 32'(b_rdy), 32'd1);
      if (i > 0) chk("b2b_wen", 32'(rf_wen), 32'd1);
      push(2'(i), 4'(i + 1));
      step();
    end
    b_val = 1'b0;
    #1;
    chk("b2b_wen_last", 32'(rf_wen), 32'd1);
    step();
    step();
    #1;
    for (int i = 0; i < 4; i++) chk("b2b_rf", 32'(rfm[i]), 32'(i + 1));

    // clear coinciding with an A handshake
    a_val  = 1'b1;
    a_addr = 2'd3;
    a_data = 4'hF;
    clear  = 1'b1;
    #1;
    chk("clrhs_ardy", 32'(a_rdy), 32'd1);
    chk("clrhs_busy", 32'(busy), 32'd0);
    push(2'd3, 4'hF);
    push_clear();
    step();
    clear  = 1'b0;
    a_addr = 2'd2;
    a_data = 4'h9;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("clrhs_ardy_low", 32'(a_rdy), 32'd0);
      chk("clrhs_busy_hi", 32'(busy), 32'd1);
      step();
    end
    // A won the last grant, so B has priority now
    b_val  = 1'b1;
    b_addr = 2'd1;
    b_data = 4'h5;
    #1;
    chk("clrhs_prio_b", 32'(b_rdy), 32'd1);
    chk("clrhs_prio_a", 32'(a_rdy), 32'd0);
    chk("clrhs_run", 32'(busy), 32'd0);
    push(2'd1, 4'h5);
    step();
    a_val = 1'b0;
    b_val = 1'b0;
    step();
    #1;
    chk("clrhs_rf3", 32'(rfm[3]), 32'd0);
    chk("clrhs_rf2", 32'(rfm[2]), 32'd0);
    chk("clrhs_rf1", 32'(rfm[1]), 32'h5);

    // reset mid-clear at cnt=2
    clear = 1'b1;
    step();
    clear = 1'b0;
    push(2'd0, 4'h0);
    push(2'd1, 4'h0);
    step();
    step();
    #5 rst_n = 1'b0;
    #1;
    chk("midrst_wen", 32'(rf_wen), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_sb", 32'(sb.size()), 32'd0);
    push_clear();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      chk("midrst_clr_wen", 32'(rf_wen), 32'd1);
    end
    step();
    #1;
    chk("midrst_done_wen", 32'(rf_wen), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
